ysyx_22040088_pcgen: RTL and testbench
======================================

Name: ysyx_22040088_pcgen

Overview:
Parametrised next-PC generator that owns the architectural fetch PC register. It selects among NSRC external redirect targets with a one-hot select, or advances sequentially by INST_BYTES. It presents the PC to IF over a valid/ready handshake and inserts a configurable post-redirect bubble. It sits between EXU branch/jump resolution and the IFU, and replaces the purely combinational next-PC mux.

Parameters:
XLEN, 64, PC and target width in bits
NSRC, 7, number of redirect target sources (one-hot select width)
RESET_PC, 64'h8000_0000, PC presented after reset (XLEN bits)
INST_BYTES, 4, sequential increment per accepted fetch
ALIGN_BITS, 2, low target bits that must be zero
REDIR_BUBBLE, 1, cycles pc_valid is held low after a redirect (0..15)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
redir_valid  in  1  redirect request this cycle
redir_sel  in  NSRC  one-hot source select, qualified by redir_valid
redir_tgt  in  NSRC*XLEN  flat targets; source i occupies bits [i*XLEN +: XLEN]
halt  in  1  stop fetch permanently (ebreak/trap-to-sim)
pc_ready  in  1  IF accepts pc this cycle
pc  out  XLEN  current fetch PC
pc_valid  out  1  pc is valid for fetch
err_sel  out  1  sticky: redir_valid with zero or multi-hot redir_sel seen
misalign  out  1  one-cycle pulse: accepted target had nonzero low ALIGN_BITS
halted  out  1  block is in HALT

Behaviour:
- Reset (async, any state, including mid-bubble): pc=RESET_PC, pc_valid=0, err_sel=0, misalign=0, halted=0, bubble counter=0, state BOOT.
- States: BOOT, RUN, BUBBLE, HALT.
- BOOT: next edge -> RUN; pc_valid=1 first cycle after the reset-release edge, pc=RESET_PC.
- Per-edge priority: halt > redirect > sequential advance.
- halt=1 in any non-HALT state: next state HALT, pc frozen, pc_valid=0, halted=1, same-cycle redirect ignored. HALT exits only via rst.
- Redirect (redir_valid=1, redir_sel nonzero) in BOOT, RUN or BUBBLE:
  - pc <= target of the lowest-index set bit.
  - Current pc is squashed whether or not it was accepted.
  - If REDIR_BUBBLE>0: counter <= REDIR_BUBBLE, state BUBBLE.
  - If REDIR_BUBBLE=0: state RUN.
- Redirect timing: redirect at edge t gives pc=target after t, pc_valid=0 for REDIR_BUBBLE cycles, then pc_valid=1.
- Redirect in BUBBLE reloads pc and restarts the counter.
- Multi-hot redir_sel: lowest index wins; err_sel set (sticky).
- redir_valid=1 with redir_sel=0: redirect ignored (treated as no redirect); err_sel set.
- redir_sel with redir_valid=0: ignored, no error.
- Misaligned accepted target: pc takes the target unmodified; misalign=1 for exactly the following cycle.
- BUBBLE: pc_valid=0, pc held, counter decrements each edge. At counter==1, next state RUN.
- RUN, no redirect/halt:
  - If pc_valid & pc_ready: pc <= pc+INST_BYTES, modulo 2^XLEN (wraps to 0, no flag).
  - Else pc is held and pc_valid stays 1 (pc stable under backpressure).
- pc and pc_valid are registered outputs; no combinational path from inputs to outputs.

Test Plan:
- Reset then pc_ready=1 for 3 cycles -> pc 0x80000000, 0x80000004, 0x80000008, pc_valid=1 from first post-reset cycle.
- pc_ready=0 for 4 cycles at pc=0x80000010 -> pc holds 0x80000010, pc_valid=1; ready=1 -> 0x80000014.
- redir_valid=1, redir_sel=7'b0000100, src2=0x80001000, REDIR_BUBBLE=1 -> next cycle pc=0x80001000 with pc_valid=0; following cycle pc_valid=1; err_sel=0.
- redir_sel=7'b0010010 (src1=0x80002000, src4=0x80003000) -> pc=0x80002000, err_sel=1 and remains 1; then redir_sel=0 with redir_valid=1 -> ignored, sequential continues.
- Redirect to 0x80000006 -> pc=0x80000006, misalign pulses 1 cycle; redirect to 0xFFFFFFFFFFFFFFFC then accept -> pc=0x0.
- halt=1 together with redirect -> pc unchanged, pc_valid=0, halted=1 for 10 cycles; rst asserted mid-bubble (REDIR_BUBBLE=3) -> immediately pc=0x80000000, pc_valid=0, BOOT.

Source files
------------

// File: rtl/ysyx_22040088_pcgen.sv
// ---------------------------------------------------------------------------
// ysyx_22040088_pcgen
//
// Next-PC generator owning the architectural fetch PC register. Chooses the
// next PC from NSRC one-hot redirect targets or a sequential advance of
// INST_BYTES. The PC is offered to IF over a valid/ready handshake, and a
// configurable bubble of invalid cycles follows every accepted redirect.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   redir_valid  redirect request this cycle
//   redir_sel    one-hot source select (lowest set bit wins if multi-hot)
//   redir_tgt    flat targets, source i at [i*XLEN +: XLEN]
//   halt         stop fetching until reset
//   pc_ready     IF accepts pc this cycle
//   pc           current fetch PC (registered)
//   pc_valid     pc is valid for fetch (registered)
//   err_sel      sticky: redirect seen with zero or multi-hot select
//   misalign     one-cycle pulse after a misaligned target was taken
//   halted       block is in HALT
// ---------------------------------------------------------------------------
module ysyx_22040088_pcgen #(
    parameter int              XLEN         = 64,
    parameter int              NSRC         = 7,
    parameter logic [XLEN-1:0] RESET_PC     = 64'h8000_0000,
    parameter int              INST_BYTES   = 4,
    parameter int              ALIGN_BITS   = 2,
    parameter int              REDIR_BUBBLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redir_valid,
    input  logic [NSRC-1:0]      redir_sel,
    input  logic [NSRC*XLEN-1:0] redir_tgt,
    input  logic                 halt,
    input  logic                 pc_ready,
    output logic [XLEN-1:0]      pc,
    output logic                 pc_valid,
    output logic                 err_sel,
    output logic                 misalign,
    output logic                 halted
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2,
        HALT   = 2'd3
    } state_t;

    // Bubble length is limited to 0..15, so a 4-bit counter is enough.
    localparam logic [3:0]      BUBBLE_LOAD = 4'(REDIR_BUBBLE);
    localparam logic [XLEN-1:0] PC_INC      = XLEN'(INST_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK  = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);
    localparam logic [NSRC-1:0] SEL_ONE     = {{(NSRC-1){1'b0}}, 1'b1};

    state_t          state;
    logic [3:0]      bub_cnt;

    logic [XLEN-1:0] redir_pc;
    logic            redir_any;
    logic            redir_multi;
    logic            redir_take;
    logic            redir_bad;
    logic            redir_misal;

    // Lowest-index priority select over the flat target bus.
    always_comb begin
        redir_pc = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (redir_sel[i]) begin
                redir_pc = redir_tgt[i*XLEN +: XLEN];
            end
        end
    end

    assign redir_any   = |redir_sel;
    // x & (x-1) clears the lowest set bit; anything left means multi-hot.
    assign redir_multi = |(redir_sel & (redir_sel - SEL_ONE));
    // An all-zero select is not a redirect, only an error.
    assign redir_take  = redir_valid & redir_any;
    assign redir_bad   = redir_valid & (~redir_any | redir_multi);
    assign redir_misal = |(redir_pc & ALIGN_MASK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            pc_valid <= 1'b0;
            err_sel  <= 1'b0;
            misalign <= 1'b0;
            halted   <= 1'b0;
            bub_cnt  <= '0;
        end else begin
            misalign <= 1'b0;

            // Once halted the select bus is no longer observed.
            if (state != HALT && redir_bad) begin
                err_sel <= 1'b1;
            end

            if (state == HALT) begin
                // Only reset leaves HALT; everything is frozen.
                pc_valid <= 1'b0;
                halted   <= 1'b1;
            end else if (halt) begin
                // Halt beats a same-cycle redirect; pc stays where it is.
                state    <= HALT;
                pc_valid <= 1'b0;
                halted   <= 1'b1;
                bub_cnt  <= '0;
            end else if (redir_take) begin
                // Current pc is squashed whether or not IF accepted it.
                pc       <= redir_pc;
                misalign <= redir_misal;
                if (BUBBLE_LOAD != 4'd0) begin
                    state    <= BUBBLE;
                    bub_cnt  <= BUBBLE_LOAD;
                    pc_valid <= 1'b0;
                end else begin
                    state    <= RUN;
                    bub_cnt  <= '0;
                    pc_valid <= 1'b1;
                end
            end else begin
                case (state)
                    BOOT: begin
                        state    <= RUN;
                        pc_valid <= 1'b1;
                    end
                    RUN: begin
                        // Under backpressure pc and pc_valid simply hold.
                        if (pc_valid && pc_ready) begin
                            pc <= pc + PC_INC;
                        end
                    end
                    BUBBLE: begin
                        if (bub_cnt <= 4'd1) begin
                            state    <= RUN;
                            bub_cnt  <= '0;
                            pc_valid <= 1'b1;
                        end else begin
                            bub_cnt <= bub_cnt - 4'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040088_pcgen.sv
module tb_ysyx_22040088_pcgen;

    localparam int XLEN = 64;
    localparam int NSRC = 7;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 redir_valid;
    logic [NSRC-1:0]      redir_sel;
    logic [NSRC*XLEN-1:0] redir_tgt;
    logic                 halt;
    logic                 pc_ready;

    logic [XLEN-1:0] pc1, pc3;
    logic            v1, v3, err1, err3, mis1, mis3, hlt1, hlt3;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Default bubble of one cycle.
    ysyx_22040088_pcgen #(.REDIR_BUBBLE(1)) u_b1 (
        .clk(clk), .rst(rst), .redir_valid(redir_valid), .redir_sel(redir_sel),
        .redir_tgt(redir_tgt), .halt(halt), .pc_ready(pc_ready),
        .pc(pc1), .pc_valid(v1), .err_sel(err1), .misalign(mis1), .halted(hlt1)
    );

    // Three-cycle bubble, used for bubble length and mid-bubble reset.
    ysyx_22040088_pcgen #(.REDIR_BUBBLE(3)) u_b3 (
        .clk(clk), .rst(rst), .redir_valid(redir_valid), .redir_sel(redir_sel),
        .redir_tgt(redir_tgt), .halt(halt), .pc_ready(pc_ready),
        .pc(pc3), .pc_valid(v3), .err_sel(err3), .misalign(mis3), .halted(hlt3)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic [63:0] p, input logic v,
                        input logic e, input logic m, input logic h);
        chk({tag, ".pc"},       pc1,  p);
        chk({tag, ".valid"},    v1,   v);
        chk({tag, ".err_sel"},  err1, e);
        chk({tag, ".misalign"}, mis1, m);
        chk({tag, ".halted"},   hlt1, h);
    endtask

    task automatic set_tgt(input int idx, input logic [63:0] t);
        redir_tgt[idx*XLEN +: XLEN] = t;
    endtask

    task automatic redirect(input logic [NSRC-1:0] sel);
        redir_valid = 1'b1;
        redir_sel   = sel;
    endtask

    task automatic no_redirect();
        redir_valid = 1'b0;
        redir_sel   = '0;
    endtask

    initial begin
        rst = 1'b1; redir_valid = 1'b0; redir_sel = '0; redir_tgt = '0;
        halt = 1'b0; pc_ready = 1'b0;
        for (int i = 0; i < NSRC; i++) set_tgt(i, 64'h0);
        #3;
        chk1("reset", 64'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);

        tick();
        rst = 1'b0;
        pc_ready = 1'b1;

        // Boot then sequential fetch.
        tick(); chk1("boot0", 64'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); chk1("seq1",  64'h8000_0004, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); chk1("seq2",  64'h8000_0008, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); chk1("seq3",  64'h8000_000C, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); chk1("seq4",  64'h8000_0010, 1'b1, 1'b0, 1'b0, 1'b0);

        // Backpressure: pc stable and valid.
        pc_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); chk1("stall", 64'h8000_0010, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        pc_ready = 1'b1;
        tick(); chk1("unstall", 64'h8000_0014, 1'b1, 1'b0, 1'b0, 1'b0);

        // Clean one-hot redirect to source 2.
        set_tgt(0, 64'h8000_0006);
        set_tgt(1, 64'h8000_2000);
        set_tgt(2, 64'h8000_1000);
        set_tgt(3, 64'hFFFF_FFFF_FFFF_FFFC);
        set_tgt(4, 64'h8000_3000);
        set_tgt(5, 64'h1234_5678);
        set_tgt(6, 64'h9ABC_DEF0);
        redirect(7'b0000100);
        tick(); chk1("redir.bub", 64'h8000_1000, 1'b0, 1'b0, 1'b0, 1'b0);
        no_redirect();
        tick(); chk1("redir.run", 64'h8000_1000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); chk1("redir.seq", 64'h8000_1004, 1'b1, 1'b0, 1'b0, 1'b0);

        // Multi-hot: lowest index (src1) wins, error sticks.
        redirect(7'b0010010);
        tick(); chk1("multi.bub", 64'h8000_2000, 1'b0, 1'b1, 1'b0, 1'b0);
        no_redirect();
        tick(); chk1("multi.run", 64'h8000_2000, 1'b1, 1'b1, 1'b0, 1'b0);

        // Valid with empty select: ignored, sequential continues.
        redirect(7'b0000000);
        tick(); chk1("zero.sel", 64'h8000_2004, 1'b1, 1'b1, 1'b0, 1'b0);
        // Select without valid: ignored.
        redir_valid = 1'b0;
        redir_sel   = 7'b0000001;
        tick(); chk1("sel.novld", 64'h8000_2008, 1'b1, 1'b1, 1'b0, 1'b0);

        // Misaligned target taken unmodified, one-cycle pulse.
        redirect(7'b0000001);
        tick(); chk1("mis.bub", 64'h8000_0006, 1'b0, 1'b1, 1'b1, 1'b0);
        no_redirect();
        tick(); chk1("mis.run", 64'h8000_0006, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); chk1("mis.seq", 64'h8000_000A, 1'b1, 1'b1, 1'b0, 1'b0);

        // Top-of-space target then wrap to zero.
        redirect(7'b0001000);
        tick(); chk1("wrap.bub", 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b1, 1'b0, 1'b0);
        no_redirect();
        tick(); chk1("wrap.run", 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); chk1("wrap.zero", 64'h0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Halt beats a same-cycle redirect; later redirects also ignored.
        halt = 1'b1;
        redirect(7'b0000100);
        tick(); chk1("halt.0", 64'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) no_redirect();
            tick(); chk1("halt.hold", 64'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        end

        // Reset both instances; async reset clears immediately.
        no_redirect();
        rst = 1'b1;
        #1;
        chk1("rst2", 64'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk("b3.boot.pc", pc3, 64'h8000_0000);
        chk("b3.boot.v",  v3,  1'b1);

        // Three-cycle bubble.
        redirect(7'b0000100);
        tick(); chk("b3.pc", pc3, 64'h8000_1000); chk("b3.v0", v3, 1'b0);
        no_redirect();
        tick(); chk("b3.v1", v3, 1'b0);
        tick(); chk("b3.v2", v3, 1'b0); chk("b3.pc.hold", pc3, 64'h8000_1000);
        tick(); chk("b3.v3", v3, 1'b1); chk("b3.pc.run", pc3, 64'h8000_1000);

        // Reset asserted mid-bubble.
        redirect(7'b0010000);
        tick(); chk("b3.mid.pc", pc3, 64'h8000_3000); chk("b3.mid.v", v3, 1'b0);
        no_redirect();
        tick(); chk("b3.mid.v2", v3, 1'b0);
        rst = 1'b1;
        #1;
        chk("b3.rst.pc",  pc3,  64'h8000_0000);
        chk("b3.rst.v",   v3,   1'b0);
        chk("b3.rst.err", err3, 1'b0);
        chk("b3.rst.hlt", hlt3, 1'b0);
        tick();
        chk("b3.rst.v.hold", v3, 1'b0);
        rst = 1'b0;
        tick();
        chk("b3.boot2.pc", pc3, 64'h8000_0000);
        chk("b3.boot2.v",  v3,  1'b1);
        chk("b3.boot2.mis", mis3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
